decode_stage: RTL and testbench

- RV32E integer decode stage, sitting directly upstream of the ALU.
- Accepts a fetched instruction and its PC over a valid/ready handshake, reads the external register file, and decodes OP, OP-IMM, LUI and AUIPC.
- Produces a registered execute bundle: ALU operation code, operand a, operand b, destination register and write enable.
- Flags illegal encodings; does not trap.

---
 rtl/core_pkg.sv | 55 +++++
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_comb.sv | 89 ++++++++
 rtl/decode_stage.sv | 73 +++++++
 tb/tb_decode_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types: ALU op codes, RV32 opcode/funct7 constants and the
// decode-to-execute bundle.
package core_pkg;

  localparam int CORE_XLEN  = 32;
  localparam int CORE_NREGS = 16;
  localparam int RADDR_W    = $clog2(CORE_NREGS);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_t              op;
    logic [CORE_XLEN-1:0] a;
    logic [CORE_XLEN-1:0] b;
    logic [RADDR_W-1:0]   rd;
    logic                 rd_we;
    logic                 illegal;
    logic [CORE_XLEN-1:0] pc;
  } exec_bundle_t;

  // Base funct3 map shared by OP and OP-IMM; the funct7 alternates are
  // resolved by the caller.
  function automatic alu_op_t f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode stage bus: fetch-side handshake, register file read/writeback,
// flush and the execute-side bundle.
interface decode_stage_if;
  import core_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [CORE_XLEN-1:0] in_pc;
  logic [RADDR_W-1:0]   rf_rs1_addr;
  logic [RADDR_W-1:0]   rf_rs2_addr;
  logic [CORE_XLEN-1:0] rf_rs1_data;
  logic [CORE_XLEN-1:0] rf_rs2_data;
  logic                 wb_we;
  logic [RADDR_W-1:0]   wb_rd;
  logic [CORE_XLEN-1:0] wb_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  alu_op_t              out_op;
  logic [CORE_XLEN-1:0] out_a;
  logic [CORE_XLEN-1:0] out_b;
  logic [RADDR_W-1:0]   out_rd;
  logic                 out_rd_we;
  logic                 out_illegal;
  logic [CORE_XLEN-1:0] out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, rf_rs1_data, rf_rs2_data,
           wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_op,
           out_a, out_b, out_rd, out_rd_we, out_illegal, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, rf_rs1_data, rf_rs2_data,
           wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, out_op,
           out_a, out_b, out_rd, out_rd_we, out_illegal, out_pc
  );

endinterface

// File: rtl/decode_comb.sv
// Combinational RV32E decoder for OP, OP-IMM, LUI and AUIPC; operand values
// arrive already bypassed.
module decode_comb
  import core_pkg::*;
(
  input  logic [31:0]          instr,
  input  logic [CORE_XLEN-1:0] pc,
  input  logic [CORE_XLEN-1:0] rs1_val,
  input  logic [CORE_XLEN-1:0] rs2_val,
  output exec_bundle_t         bundle
);

  logic [6:0]           opc, f7;
  logic [2:0]           f3;
  logic [4:0]           rd5, rs1_5, rs2_5;
  logic [CORE_XLEN-1:0] imm_i, imm_u, a, b;
  logic                 ill, use_rs1, use_rs2, use_rd;
  alu_op_t              op;

  assign opc   = instr[6:0];
  assign rd5   = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1_5 = instr[19:15];
  assign rs2_5 = instr[24:20];
  assign f7    = instr[31:25];
  assign imm_i = {{(CORE_XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};

  function automatic logic reg_ok(input logic [4:0] r);
    return r < 5'(CORE_NREGS);
  endfunction

  always_comb begin
    op      = ALU_ADD;
    a       = '0;
    b       = '0;
    ill     = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opc)
      OPC_OP: begin
        {use_rs1, use_rs2, use_rd} = 3'b111;
        a = rs1_val;
        b = rs2_val;
        if (f7 == F7_BASE)                     op = f3_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) op = ALU_SRA;
        else                                   ill = 1'b1;
      end
      OPC_OP_IMM: begin
        {use_rs1, use_rd} = 2'b11;
        a  = rs1_val;
        b  = imm_i;
        op = f3_op(f3);
        // Only the shift forms give the upper immediate bits a funct7 meaning.
        if (f3 == 3'b001 && f7 != F7_BASE) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)        op  = ALU_SRA;
          else if (f7 != F7_BASE)  ill = 1'b1;
        end
      end
      OPC_LUI: begin
        use_rd = 1'b1;
        b      = imm_u;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1;
        a      = pc;
        b      = imm_u;
      end
      default: ill = 1'b1;
    endcase
    if ((use_rs1 && !reg_ok(rs1_5)) || (use_rs2 && !reg_ok(rs2_5)) ||
        (use_rd && !reg_ok(rd5)))
      ill = 1'b1;
  end

  always_comb begin
    bundle.op      = ill ? ALU_ADD : op;
    bundle.a       = ill ? '0 : a;
    bundle.b       = ill ? '0 : b;
    bundle.rd      = rd5[RADDR_W-1:0];
    bundle.rd_we   = !ill && use_rd && (rd5 != 5'd0);
    bundle.illegal = ill;
    bundle.pc      = pc;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: valid/ready handshake, writeback bypass on the
// register file reads and a single registered execute bundle.
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int NREGS = CORE_NREGS
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1_a, rs2_a;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            vld_q, accept;
  exec_bundle_t    dec, q;

  assign rs1_a           = bus.in_instr[15 +: AW];
  assign rs2_a           = bus.in_instr[20 +: AW];
  assign bus.rf_rs1_addr = rs1_a;
  assign bus.rf_rs2_addr = rs2_a;

  // x0 is hard zero; otherwise a same-cycle writeback wins over the
  // non-write-through register file.
  function automatic logic [XLEN-1:0] rd_val(input logic [AW-1:0] idx,
                                             input logic [XLEN-1:0] rf);
    if (idx == '0)                         return '0;
    if (bus.wb_we && bus.wb_rd == idx)     return bus.wb_data;
    return rf;
  endfunction

  assign rs1_val = rd_val(rs1_a, bus.rf_rs1_data);
  assign rs2_val = rd_val(rs2_a, bus.rf_rs2_data);

  decode_comb u_dec (
    .instr   (bus.in_instr),
    .pc      (bus.in_pc),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .bundle  (dec)
  );

  assign bus.in_ready = !bus.flush && (!vld_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      q     <= '{op: ALU_ADD, a: '0, b: '0, rd: '0, rd_we: 1'b0,
                 illegal: 1'b0, pc: '0};
    end else if (bus.flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      q     <= dec;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.out_op      = q.op;
  assign bus.out_a       = q.a;
  assign bus.out_b       = q.b;
  assign bus.out_rd      = q.rd;
  assign bus.out_rd_we   = q.rd_we;
  assign bus.out_illegal = q.illegal;
  assign bus.out_pc      = q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of single-instruction vectors plus
// hand-written backpressure, flush and async-reset sequences.
module tb_decode_stage;
  import core_pkg::*;

  logic clk, rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, r1, r2;
    logic        wbwe;
    logic [3:0]  wbrd;
    logic [31:0] wbd;
    alu_op_t     op;
    logic [31:0] a, b;
    logic [3:0]  rd;
    logic        we, ill;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] instr, pc, r1, r2, input logic wbwe,
                     input logic [3:0] wbrd, input logic [31:0] wbd,
                     input alu_op_t op, input logic [31:0] a, b,
                     input logic [3:0] rd, input logic we, ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.r1 = r1; v.r2 = r2;
    v.wbwe = wbwe; v.wbrd = wbrd; v.wbd = wbd;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.we = we; v.ill = ill;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, pc, r1, r2, input logic wbwe,
                       input logic [3:0] wbrd, input logic [31:0] wbd);
    bus.in_instr = instr; bus.in_pc = pc;
    bus.rf_rs1_data = r1; bus.rf_rs2_data = r2;
    bus.wb_we = wbwe; bus.wb_rd = wbrd; bus.wb_data = wbd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input string nm, input vec_t v);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, ".op"},    32'(bus.out_op),    32'(v.op));
    chk({nm, ".a"},     bus.out_a,          v.a);
    chk({nm, ".b"},     bus.out_b,          v.b);
    if (!v.ill) chk({nm, ".rd"}, 32'(bus.out_rd), 32'(v.rd));
    chk({nm, ".rd_we"}, 32'(bus.out_rd_we), 32'(v.we));
    chk({nm, ".ill"},   32'(bus.out_illegal), 32'(v.ill));
    chk({nm, ".pc"},    bus.out_pc,         v.pc);
  endtask

  initial begin
    vec_t va, vb;
    // instr, pc, rs1d, rs2d, wb_we, wb_rd, wb_data | op, a, b, rd, rd_we, ill
    add(32'hFFF18293, 32'h0, 32'd10, 32'd0, 0, 0, 0, ALU_ADD, 32'd10, 32'hFFFFFFFF, 5, 1, 0); // ADDI x5,x3,-1
    add(32'h403100B3, 32'h4, 32'd7,  32'd9, 1, 2, 100, ALU_SUB, 32'd100, 32'd9, 1, 1, 0);     // SUB bypass rs1
    add(32'h403100B3, 32'h8, 32'd7,  32'd9, 1, 0, 100, ALU_SUB, 32'd7, 32'd9, 1, 1, 0);       // wb to x0 no bypass
    add(32'h403000B3, 32'hC, 32'd55, 32'd9, 1, 0, 100, ALU_SUB, 32'd0, 32'd9, 1, 1, 0);       // x0 reads zero
    add(32'h00208333, 32'h10, 32'd3, 32'd4, 1, 2, 32'h55, ALU_ADD, 32'd3, 32'h55, 6, 1, 0);   // bypass rs2
    add(32'h12345217, 32'h100, 32'd1, 32'd2, 0, 0, 0, ALU_ADD, 32'h100, 32'h12345000, 4, 1, 0); // AUIPC
    add(32'h00001037, 32'h104, 32'd1, 32'd2, 0, 0, 0, ALU_ADD, 32'd0, 32'h1000, 0, 0, 0);     // LUI x0
    add(32'hABCDE3B7, 32'h108, 32'd1, 32'd2, 0, 0, 0, ALU_ADD, 32'd0, 32'hABCDE000, 7, 1, 0); // LUI x7
    add(32'h00419133, 32'h10C, 32'd1, 32'd5, 0, 0, 0, ALU_SLL, 32'd1, 32'd5, 2, 1, 0);        // SLL
    add(32'h40355493, 32'h110, 32'hF0000000, 32'd0, 0, 0, 0, ALU_SRA, 32'hF0000000, 32'h403, 9, 1, 0); // SRAI
    add(32'h7FF14093, 32'h114, 32'h0F, 32'd0, 0, 0, 0, ALU_XOR, 32'h0F, 32'h7FF, 1, 1, 0);    // XORI
    add(32'h8000B193, 32'h118, 32'd6, 32'd0, 0, 0, 0, ALU_SLTU, 32'd6, 32'hFFFFF800, 3, 1, 0); // SLTIU
    add(32'h00D777B3, 32'h11C, 32'hF0F0, 32'hFF00, 0, 0, 0, ALU_AND, 32'hF0F0, 32'hFF00, 15, 1, 0); // AND
    add(32'h00208033, 32'h120, 32'd3, 32'd4, 0, 0, 0, ALU_ADD, 32'd3, 32'd4, 0, 0, 0);        // ADD x0
    add(32'h01010093, 32'h124, 32'd1, 32'd9, 0, 0, 0, ALU_ADD, 32'd1, 32'd16, 1, 1, 0);       // ADDI imm bit24 legal
    add(32'h00208833, 32'h128, 32'd3, 32'd4, 0, 0, 0, ALU_ADD, 32'd0, 32'd0, 0, 0, 1);        // rd=x16
    add(32'h40111093, 32'h12C, 32'd3, 32'd4, 0, 0, 0, ALU_ADD, 32'd0, 32'd0, 1, 0, 1);        // SLLI bad f7
    add(32'h00012083, 32'h130, 32'd3, 32'd4, 0, 0, 0, ALU_ADD, 32'd0, 32'd0, 1, 0, 1);        // LW opcode
    add(32'h023100B3, 32'h134, 32'd3, 32'd4, 0, 0, 0, ALU_ADD, 32'd0, 32'd0, 1, 0, 1);        // f7=0000001
    add(32'h403110B3, 32'h138, 32'd3, 32'd4, 0, 0, 0, ALU_ADD, 32'd0, 32'd0, 1, 0, 1);        // ALT with SLL
    add(32'h002880B3, 32'h13C, 32'd3, 32'd4, 0, 0, 0, ALU_ADD, 32'd0, 32'd0, 1, 0, 1);        // rs1=x17

    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    #12;
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.op",    32'(bus.out_op),    32'(ALU_ADD));
    chk("rst.a",     bus.out_a,          32'd0);
    chk("rst.b",     bus.out_b,          32'd0);
    chk("rst.pc",    bus.out_pc,         32'd0);
    chk("rst.rd",    32'(bus.out_rd),    32'd0);
    chk("rst.we",    32'(bus.out_rd_we), 32'd0);
    chk("rst.ill",   32'(bus.out_illegal), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // back-to-back stream through the table at full throughput
    foreach (tbl[i]) begin
      drive(tbl[i].instr, tbl[i].pc, tbl[i].r1, tbl[i].r2,
            tbl[i].wbwe, tbl[i].wbrd, tbl[i].wbd);
      bus.in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      chk($sformatf("v%0d.rs1_addr", i), 32'(bus.rf_rs1_addr), 32'(tbl[i].instr[18:15]));
      chk($sformatf("v%0d.rs2_addr", i), 32'(bus.rf_rs2_addr), 32'(tbl[i].instr[23:20]));
      tick();
      chk_bundle($sformatf("v%0d", i), tbl[i]);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain.valid", 32'(bus.out_valid), 32'd0);

    // backpressure: A held bit-stable while B waits, then both in order
    va = tbl[0];
    vb = tbl[4];
    bus.out_ready = 1'b0;
    drive(va.instr, va.pc, va.r1, va.r2, va.wbwe, va.wbrd, va.wbd);
    bus.in_valid = 1'b1;
    tick();
    drive(vb.instr, vb.pc, vb.r1, vb.r2, vb.wbwe, vb.wbrd, vb.wbd);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", c), 32'(bus.in_ready), 32'd0);
      chk_bundle($sformatf("bp%0d.A", c), va);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk_bundle("bp.B", vb);
    bus.in_valid = 1'b0;
    tick();
    chk("bp.drained", 32'(bus.out_valid), 32'd0);

    // flush while a bundle is stalled and a new instruction is offered
    bus.out_ready = 1'b0;
    drive(va.instr, va.pc, va.r1, va.r2, 0, 0, 0);
    bus.in_valid = 1'b1;
    tick();
    chk("fl.pre.valid", 32'(bus.out_valid), 32'd1);
    drive(tbl[7].instr, tbl[7].pc, tbl[7].r1, tbl[7].r2, 0, 0, 0);
    bus.flush = 1'b1;
    #1;
    chk("fl.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("fl.valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("fl.no_accept", 32'(bus.out_valid), 32'd0);

    // asynchronous reset mid-stream
    drive(va.instr, va.pc, va.r1, va.r2, 0, 0, 0);
    bus.in_valid = 1'b1;
    tick();
    chk("ar.pre.valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(bus.out_valid), 32'd0);
    chk("ar.a",     bus.out_a,          32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("ar.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("ar.post.valid", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
